wrr_table_arbiter: RTL and testbench
====================================

// Module: wrr_table_arbiter
// PURPOSE
//  Weighted round-robin arbiter driven by a programmable arbitration table of
//  TABLE_SIZE entries, each entry being a (queue select, weight) pair. Sits between
//  the QUEUE_QUANTITY FIFO banks and the output mux of the roundRobin path.
//  Handshaked with downstream: credit is consumed only on accepted transfers.
//  Work-conserving: entries whose queue is empty or whose weight is 0 are skipped.
//  The table is double-buffered; new contents take effect at a round boundary.
// PARAMETERS
//  QUEUE_QUANTITY  4  number of FIFO queues arbitrated (>=2)
//  TABLE_SIZE      8  arbitration table entries (>=2)
//  WEIGHT_BITS     6  width of each entry weight; max weight 2**WEIGHT_BITS-1
//  SEL_BITS (local) = $clog2(QUEUE_QUANTITY); IDX_BITS (local) = $clog2(TABLE_SIZE)
// PORTS
//  clk            in   1                       clock
//  rst            in   1                       synchronous reset, active-high
//  enb            in   1                       block enable; low freezes arbitration state
//  cfg_pesos      in   TABLE_SIZE*WEIGHT_BITS  entry weights, entry n at [n*WEIGHT_BITS +: WEIGHT_BITS]
//  cfg_selec      in   TABLE_SIZE*SEL_BITS     entry queue selects, entry n at [n*SEL_BITS +: SEL_BITS]
//  cfg_load       in   1                       pulse: capture cfg_* into shadow table
//  buf_empty      in   QUEUE_QUANTITY          per-queue FIFO empty flags
//  pop_ack        in   1                       downstream accepted the current grant this cycle
//  selector       out  SEL_BITS                granted queue index
//  selector_enb   out  1                       grant valid
//  entry_idx      out  IDX_BITS                current table entry (debug/verification)
//  round_done     out  1                       1-cycle pulse when index wraps TABLE_SIZE-1 -> 0
//  cfg_pending    out  1                       shadow table loaded but not yet active
// BEHAVIOUR
//  - Reset: active and shadow tables <= cfg_pesos/cfg_selec; entry_idx=0; credit=weight[0];
//    round_done=0; cfg_pending=0; selector=0; selector_enb=0.
//  - Grant (combinational from state): selector_enb = enb & ~rst & ~buf_empty[sel[idx]] & (credit!=0);
//    selector = selector_enb ? sel[idx] : 0.
//  - Transfer = selector_enb & pop_ack. On transfer credit decrements by 1. pop_ack ignored otherwise.
//  - Advance to idx+1 (wrap to 0 after TABLE_SIZE-1) when enb and any of: transfer with credit==1;
//    credit==0 (weight-0 entry); selected queue empty. One entry advanced per cycle max.
//  - On advance, credit <= weight of the new entry from the table active after that edge.
//  - Stall: queue non-empty, credit>0, pop_ack=0 -> hold idx and credit indefinitely.
//  - Wrap: round_done=1 for the cycle after the wrap edge. If cfg_pending (or cfg_load same
//    cycle) the active table <= shadow (cfg_load same cycle: cfg_* inputs win); cfg_pending <= 0.
//  - cfg_load is captured regardless of enb; sets cfg_pending=1 unless coinciding with a wrap.
//    Repeated cfg_load before wrap: last one wins.
//  - enb=0: idx, credit, round_done(=0) frozen; selector_enb=0.
//  - All weights 0 or all queues empty: selector_enb stays 0; idx sweeps one entry/cycle,
//    round_done pulses every TABLE_SIZE cycles (so pending configs still apply).
//  - rst mid-operation overrides everything, incl. a concurrent cfg_load (cfg_* captured by reset).
//  - Credit width WEIGHT_BITS, never underflows (decrement only when credit!=0).
// TESTING
//  1 Table sel={0,1,2,3,0,1,2,3}, w={2,1,3,1,0,0,0,0}, all queues full, pop_ack=1 ->
//    grant sequence 0,0,1,2,2,2,3 then 4 skip cycles, round_done pulse, sequence repeats.
//  2 Same table, pop_ack held 0 for 5 cycles at entry 0 -> selector=0 held, credit stays 2,
//    idx stays 0; resumes with exactly 2 grants of queue 0.
//  3 buf_empty=4'b0010 -> entry 1 skipped in one cycle, no grant of queue 1, order 0,0,2,2,2,3.
//  4 cfg_load mid-round with w={1,1,1,1,1,1,1,1} -> cfg_pending=1, old weights finish round,
//    new table active from first entry after round_done; cfg_pending=0.
//  5 enb=0 for 3 cycles mid-entry -> selector_enb=0, idx/credit unchanged, continues after.
//  6 rst asserted mid-round with new cfg_* -> next cycle idx=0, credit=new weight[0],
//    cfg_pending=0, outputs 0 during reset.

Source files
------------

// File: rtl/wrr_table_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wrr_table_arbiter
// Purpose  : Table-driven weighted round-robin arbiter. Each of the TABLE_SIZE
//            entries names a queue and a weight (number of grants). Credit is
//            spent only on accepted transfers. Entries whose queue is empty or
//            whose weight is 0 are skipped one per cycle. The table is
//            double-buffered; a loaded shadow table becomes active when the
//            entry index wraps back to 0.
// Ports    : clk, rst          clock, synchronous active-high reset
//            enb               block enable (low freezes arbitration state)
//            cfg_pesos         packed entry weights
//            cfg_selec         packed entry queue selects
//            cfg_load          capture cfg_* into the shadow table
//            buf_empty         per-queue FIFO empty flags
//            pop_ack           downstream accepted the current grant
//            selector          granted queue index
//            selector_enb      grant valid
//            entry_idx         current table entry
//            round_done        1-cycle pulse after the index wraps
//            cfg_pending       shadow table loaded, not yet active
// Revision : 1.0 - initial release
// ============================================================================
module wrr_table_arbiter #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int TABLE_SIZE     = 8,
  parameter int WEIGHT_BITS    = 6,
  localparam int SEL_BITS      = $clog2(QUEUE_QUANTITY),
  localparam int IDX_BITS      = $clog2(TABLE_SIZE)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enb,
  input  logic [TABLE_SIZE*WEIGHT_BITS-1:0] cfg_pesos,
  input  logic [TABLE_SIZE*SEL_BITS-1:0]  cfg_selec,
  input  logic                            cfg_load,
  input  logic [QUEUE_QUANTITY-1:0]       buf_empty,
  input  logic                            pop_ack,
  output logic [SEL_BITS-1:0]             selector,
  output logic                            selector_enb,
  output logic [IDX_BITS-1:0]             entry_idx,
  output logic                            round_done,
  output logic                            cfg_pending
);

  localparam logic [IDX_BITS-1:0]    c_LAST_IDX = IDX_BITS'(TABLE_SIZE - 1);
  localparam logic [WEIGHT_BITS-1:0] c_ONE      = WEIGHT_BITS'(1);

  // Unpacked views of the configuration inputs
  logic [WEIGHT_BITS-1:0] w_cfg_w [TABLE_SIZE];
  logic [SEL_BITS-1:0]    w_cfg_s [TABLE_SIZE];

  for (genvar n = 0; n < TABLE_SIZE; n++) begin : g_unpack
    assign w_cfg_w[n] = cfg_pesos[n*WEIGHT_BITS +: WEIGHT_BITS];
    assign w_cfg_s[n] = cfg_selec[n*SEL_BITS +: SEL_BITS];
  end

  // Active and shadow tables
  logic [WEIGHT_BITS-1:0] r_act_w [TABLE_SIZE];
  logic [SEL_BITS-1:0]    r_act_s [TABLE_SIZE];
  logic [WEIGHT_BITS-1:0] r_sh_w  [TABLE_SIZE];
  logic [SEL_BITS-1:0]    r_sh_s  [TABLE_SIZE];

  logic [IDX_BITS-1:0]    r_idx;
  logic [WEIGHT_BITS-1:0] r_credit;
  logic                   r_round_done;
  logic                   r_pending;

  logic [SEL_BITS-1:0]    w_cur_sel;
  logic                   w_q_empty;
  logic                   w_grant;
  logic                   w_xfer;
  logic                   w_advance;
  logic                   w_wrap;
  logic                   w_swap;
  logic [IDX_BITS-1:0]    w_next_idx;
  logic [WEIGHT_BITS-1:0] w_next_credit;

  assign w_cur_sel = r_act_s[r_idx];

  // Selects that do not name a real queue are treated as empty queues.
  always_comb begin
    w_q_empty = 1'b1;
    for (int q = 0; q < QUEUE_QUANTITY; q++) begin
      if (w_cur_sel == SEL_BITS'(q)) w_q_empty = buf_empty[q];
    end
  end

  assign w_grant   = enb & ~rst & ~w_q_empty & (r_credit != '0);
  assign w_xfer    = w_grant & pop_ack;

  // Move on when the last credit is spent, the entry has no credit, or the
  // queue has nothing to offer (work-conserving skip).
  assign w_advance = enb & ((w_xfer & (r_credit == c_ONE)) |
                            (r_credit == '0) | w_q_empty);
  assign w_wrap    = w_advance & (r_idx == c_LAST_IDX);

  // Table swap happens on the wrap edge; a same-cycle load bypasses the shadow.
  assign w_swap     = w_wrap & (r_pending | cfg_load);
  assign w_next_idx = (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;

  // Credit of the next entry comes from whichever table is active after the edge.
  always_comb begin
    if (w_swap) begin
      w_next_credit = cfg_load ? w_cfg_w[w_next_idx] : r_sh_w[w_next_idx];
    end else begin
      w_next_credit = r_act_w[w_next_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < TABLE_SIZE; n++) begin
        r_act_w[n] <= w_cfg_w[n];
        r_act_s[n] <= w_cfg_s[n];
        r_sh_w[n]  <= w_cfg_w[n];
        r_sh_s[n]  <= w_cfg_s[n];
      end
      r_idx        <= '0;
      r_credit     <= w_cfg_w[0];
      r_round_done <= 1'b0;
      r_pending    <= 1'b0;
    end else begin
      if (cfg_load) begin
        for (int n = 0; n < TABLE_SIZE; n++) begin
          r_sh_w[n] <= w_cfg_w[n];
          r_sh_s[n] <= w_cfg_s[n];
        end
      end

      if (w_swap) begin
        for (int n = 0; n < TABLE_SIZE; n++) begin
          r_act_w[n] <= cfg_load ? w_cfg_w[n] : r_sh_w[n];
          r_act_s[n] <= cfg_load ? w_cfg_s[n] : r_sh_s[n];
        end
      end

      if (w_wrap) begin
        r_pending <= 1'b0;
      end else if (cfg_load) begin
        r_pending <= 1'b1;
      end

      if (w_advance) begin
        r_idx    <= w_next_idx;
        r_credit <= w_next_credit;
      end else if (w_xfer) begin
        r_credit <= r_credit - c_ONE;
      end

      r_round_done <= w_wrap;
    end
  end

  assign selector_enb = w_grant;
  assign selector     = w_grant ? w_cur_sel : '0;
  assign entry_idx    = r_idx;
  assign round_done   = r_round_done;
  assign cfg_pending  = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_wrr_table_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wrr_table_arbiter
// Purpose  : Self-checking bench for wrr_table_arbiter. A behavioural model
//            predicts the outputs of every cycle; predictions are queued when
//            the stimulus is applied and compared once the DUT output settles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wrr_table_arbiter;

  localparam int QQ = 4;
  localparam int TS = 8;
  localparam int WB = 6;
  localparam int SB = 2;
  localparam int IB = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              enb;
  logic [TS*WB-1:0]  cfg_pesos;
  logic [TS*SB-1:0]  cfg_selec;
  logic              cfg_load;
  logic [QQ-1:0]     buf_empty;
  logic              pop_ack;
  logic [SB-1:0]     selector;
  logic              selector_enb;
  logic [IB-1:0]     entry_idx;
  logic              round_done;
  logic              cfg_pending;

  wrr_table_arbiter #(
    .QUEUE_QUANTITY(QQ),
    .TABLE_SIZE    (TS),
    .WEIGHT_BITS   (WB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enb         (enb),
    .cfg_pesos   (cfg_pesos),
    .cfg_selec   (cfg_selec),
    .cfg_load    (cfg_load),
    .buf_empty   (buf_empty),
    .pop_ack     (pop_ack),
    .selector    (selector),
    .selector_enb(selector_enb),
    .entry_idx   (entry_idx),
    .round_done  (round_done),
    .cfg_pending (cfg_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sel;
    int en;
    int idx;
    int rd;
    int pend;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model state
  int m_aw[TS];
  int m_as[TS];
  int m_sw[TS];
  int m_ss[TS];
  int m_idx, m_cr, m_pend, m_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int cfg_w(input int n);
    return int'(cfg_pesos[n*WB +: WB]);
  endfunction

  function automatic int cfg_s(input int n);
    return int'(cfg_selec[n*SB +: SB]);
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    bit   emp;
    emp    = buf_empty[m_as[m_idx]];
    e.en   = (enb && !rst && !emp && m_cr > 0) ? 1 : 0;
    e.sel  = e.en ? m_as[m_idx] : 0;
    e.idx  = m_idx;
    e.rd   = m_rd;
    e.pend = m_pend;
    return e;
  endfunction

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    bit emp, grant, xfer, adv, wrap;
    if (rst) begin
      for (int n = 0; n < TS; n++) begin
        m_aw[n] = cfg_w(n); m_sw[n] = cfg_w(n);
        m_as[n] = cfg_s(n); m_ss[n] = cfg_s(n);
      end
      m_idx = 0; m_cr = m_aw[0]; m_pend = 0; m_rd = 0;
    end else begin
      emp   = buf_empty[m_as[m_idx]];
      grant = enb && !emp && m_cr > 0;
      xfer  = grant && pop_ack;
      adv   = enb && (m_cr == 0 || emp || (xfer && m_cr == 1));
      wrap  = adv && (m_idx == TS - 1);
      if (wrap && (m_pend != 0 || cfg_load)) begin
        for (int n = 0; n < TS; n++) begin
          m_aw[n] = cfg_load ? cfg_w(n) : m_sw[n];
          m_as[n] = cfg_load ? cfg_s(n) : m_ss[n];
        end
      end
      if (cfg_load) begin
        for (int n = 0; n < TS; n++) begin
          m_sw[n] = cfg_w(n);
          m_ss[n] = cfg_s(n);
        end
      end
      if (wrap) m_pend = 0;
      else if (cfg_load) m_pend = 1;
      if (adv) begin
        m_idx = (m_idx + 1) % TS;
        m_cr  = m_aw[m_idx];
      end else if (xfer) begin
        m_cr = m_cr - 1;
      end
      m_rd = wrap ? 1 : 0;
    end
  endtask

  // One cycle: predict, compare settled outputs, then clock both DUT and model.
  // c_sel/c_en/c_rd >= 0 add a directed check against fixed expected values.
  task automatic step(input int c_sel = -1, input int c_en = -1, input int c_rd = -1);
    exp_t e;
    exp_q.push_back(model_out());
    #1;
    e = exp_q.pop_front();
    check("selector",     32'(selector),     32'(e.sel));
    check("selector_enb", 32'(selector_enb), 32'(e.en));
    check("entry_idx",    32'(entry_idx),    32'(e.idx));
    check("round_done",   32'(round_done),   32'(e.rd));
    check("cfg_pending",  32'(cfg_pending),  32'(e.pend));
    if (c_sel >= 0) check("dir_selector",   32'(selector),     32'(c_sel));
    if (c_en  >= 0) check("dir_enb",        32'(selector_enb), 32'(c_en));
    if (c_rd  >= 0) check("dir_round_done", 32'(round_done),   32'(c_rd));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Directed grant sequence for the base table: 0,0,1,2,2,2,3, four skips, then wrap pulse.
  int t1_sel[12] = '{0, 0, 1, 2, 2, 2, 3, 0, 0, 0, 0, 0};
  int t1_en [12] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1};
  int t1_rd [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

  localparam logic [TS*WB-1:0] c_W_BASE = {6'd0, 6'd0, 6'd0, 6'd0, 6'd1, 6'd3, 6'd1, 6'd2};
  localparam logic [TS*SB-1:0] c_S_BASE = {2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
  localparam logic [TS*WB-1:0] c_W_ONES = {8{6'd1}};
  localparam logic [TS*WB-1:0] c_W_FIVE = {8{6'd5}};
  localparam logic [TS*SB-1:0] c_S_REV  = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};

  initial begin
    rst = 1'b1; enb = 1'b1; cfg_load = 1'b0; buf_empty = '0; pop_ack = 1'b1;
    cfg_pesos = c_W_BASE; cfg_selec = c_S_BASE;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    // Outputs while reset is held
    step(0, 0, 0);
    rst = 1'b0;

    // Base sequence, first round directed, then two more rounds
    for (int i = 0; i < 12; i++) step(t1_sel[i], t1_en[i], t1_rd[i]);
    run(10);

    // Downstream stall at entry 0: selector held, then exactly 2 grants of queue 0
    pop_ack = 1'b0;
    for (int i = 0; i < 5; i++) step(0, 1, -1);
    pop_ack = 1'b1;
    step(0, 1, -1);
    step(0, 1, -1);
    step(1, 1, -1);
    run(8);

    // Queue 1 empty: entry 1 skipped in a single cycle
    buf_empty = 4'b0010;
    run(22);
    buf_empty = '0;
    run(5);

    // Mid-round load of unit weights; old table finishes the round
    cfg_pesos = c_W_ONES; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0; cfg_pesos = c_W_BASE;
    run(24);

    // Enable low for 3 cycles mid-entry
    run(3);
    enb = 1'b0;
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    enb = 1'b1;
    run(12);

    // Two loads before the wrap: the second one wins; first load with enb low
    enb = 1'b0; cfg_pesos = c_W_FIVE; cfg_load = 1'b1;
    step();
    enb = 1'b1; cfg_pesos = c_W_BASE; cfg_selec = c_S_REV;
    step();
    cfg_load = 1'b0;
    run(30);

    // All queues empty with a pending config: sweep one entry per cycle
    cfg_pesos = c_W_ONES; cfg_selec = c_S_BASE; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    buf_empty = 4'hF;
    run(18);
    buf_empty = '0;
    run(10);

    // Reset mid-round with new configuration and a concurrent load
    run(3);
    cfg_pesos = c_W_FIVE; cfg_selec = c_S_REV; rst = 1'b1; cfg_load = 1'b1;
    step(0, 0, -1);
    rst = 1'b0; cfg_load = 1'b0;
    step(3, 1, 0);
    run(20);

    // Randomised traffic with occasional reloads
    for (int i = 0; i < 400; i++) begin
      buf_empty = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      pop_ack   = ($urandom_range(0, 3) != 0);
      enb       = ($urandom_range(0, 7) != 0);
      cfg_load  = ($urandom_range(0, 15) == 0);
      if (cfg_load) begin
        for (int n = 0; n < TS; n++) begin
          cfg_pesos[n*WB +: WB] = 6'($urandom_range(0, 3));
          cfg_selec[n*SB +: SB] = 2'($urandom_range(0, 3));
        end
      end
      step();
    end
    cfg_load = 1'b0;

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
